// File: rtl/timebase_capture_ctrl.sv
// Timebase divider plus trigger/capture sequencer feeding the display frame RAM.
// Latency: sample_en one cycle after divider terminal count; wr_en same cycle as sample_en.
// Backpressure: none on the sample path; a finished frame is held in DONE until rd_done.
module timebase_capture_ctrl #(
  parameter int NUM_SAMPLES  = 640,
  parameter int ADDR_W       = 10,
  parameter int AUTO_SAMPLES = 2048,
  parameter int TB_RESET     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tb_up,
  input  logic              tb_down,
  input  logic              trig,
  input  logic              rd_done,
  output logic [2:0]        tb_sel,
  output logic              sample_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              frame_ready,
  output logic              auto_trig
);

  localparam int AUTO_W = $clog2(AUTO_SAMPLES + 1);

  typedef enum logic [1:0] {ARM, WAIT_TRIG, CAPTURE, DONE} state_t;

  state_t            state, state_nxt;
  logic [16:0]       div_cnt;
  logic [16:0]       div_last;
  logic [AUTO_W-1:0] auto_cnt, auto_cnt_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic              auto_trig_nxt;
  logic              step_up, step_down, tb_change, auto_hit;

  // A request only counts when it actually moves tb_sel; opposing pulses cancel.
  assign step_up   = tb_up & ~tb_down & (tb_sel != 3'd7);
  assign step_down = tb_down & ~tb_up & (tb_sel != 3'd0);
  assign tb_change = step_up | step_down;

  // Auto counter is about to reach AUTO_SAMPLES on this strobe.
  assign auto_hit  = (auto_cnt == AUTO_W'(AUTO_SAMPLES - 1));

  // Terminal count (DIV-1) for each timebase index.
  always_comb begin
    div_last = 17'd0;
    case (tb_sel)
      3'd0: div_last = 17'd0;
      3'd1: div_last = 17'd1;
      3'd2: div_last = 17'd4;
      3'd3: div_last = 17'd9;
      3'd4: div_last = 17'd99;
      3'd5: div_last = 17'd999;
      3'd6: div_last = 17'd9999;
      default: div_last = 17'd99999;
    endcase
  end

  // Timebase index register, stepped by effective up/down requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_sel <= 3'(TB_RESET);
    end else if (step_up) begin
      tb_sel <= tb_sel + 3'd1;
    end else if (step_down) begin
      tb_sel <= tb_sel - 3'd1;
    end
  end

  // Sample-rate divider; a timebase change restarts it and suppresses the next strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= 17'd0;
      sample_en <= 1'b0;
    end else if (tb_change) begin
      div_cnt   <= 17'd0;
      sample_en <= 1'b0;
    end else if (div_cnt == div_last) begin
      div_cnt   <= 17'd0;
      sample_en <= 1'b1;
    end else begin
      div_cnt   <= div_cnt + 17'd1;
      sample_en <= 1'b0;
    end
  end

  // Capture sequencer state and its datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARM;
      wr_addr   <= '0;
      auto_cnt  <= '0;
      auto_trig <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_addr   <= wr_addr_nxt;
      auto_cnt  <= auto_cnt_nxt;
      auto_trig <= auto_trig_nxt;
    end
  end

  // Next state, write strobe and status; a timebase change aborts to ARM with no write.
  always_comb begin
    state_nxt     = state;
    wr_addr_nxt   = wr_addr;
    auto_cnt_nxt  = auto_cnt;
    auto_trig_nxt = auto_trig;
    wr_en         = 1'b0;
    busy          = (state == WAIT_TRIG) || (state == CAPTURE);
    frame_ready   = (state == DONE);
    if (tb_change) begin
      state_nxt = ARM;
    end else begin
      case (state)
        ARM: begin
          wr_addr_nxt  = '0;
          auto_cnt_nxt = '0;
          state_nxt    = WAIT_TRIG;
        end
        WAIT_TRIG: begin
          if (sample_en) begin
            auto_cnt_nxt = auto_cnt + AUTO_W'(1);
            if (trig || auto_hit) begin
              wr_en         = 1'b1;
              auto_trig_nxt = ~trig;
              wr_addr_nxt   = ADDR_W'(1);
              state_nxt     = CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (sample_en) begin
            wr_en = 1'b1;
            if (wr_addr == ADDR_W'(NUM_SAMPLES - 1)) begin
              state_nxt = DONE;
            end else begin
              wr_addr_nxt = wr_addr + ADDR_W'(1);
            end
          end
        end
        default: begin
          if (rd_done) begin
            state_nxt = ARM;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timebase_capture_ctrl.sv
// Randomized and directed bench for timebase_capture_ctrl against a behavioural model.
// Model is checked on every falling edge; inputs change 1ns after each rising edge.
// Directed phases pin the model with hand-computed literal expectations.
module tb_timebase_capture_ctrl;
  localparam int N    = 640;
  localparam int AW   = 10;
  localparam int AUTO = 2048;

  logic clk = 1'b0, rst_n = 1'b0;
  logic tb_up = 1'b0, tb_down = 1'b0, trig = 1'b0, rd_done = 1'b0;
  logic [2:0] tb_sel;
  logic sample_en, wr_en, busy, frame_ready, auto_trig;
  logic [AW-1:0] wr_addr;

  timebase_capture_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tb_up(tb_up), .tb_down(tb_down), .trig(trig),
    .rd_done(rd_done), .tb_sel(tb_sel), .sample_en(sample_en), .wr_en(wr_en),
    .wr_addr(wr_addr), .busy(busy), .frame_ready(frame_ready), .auto_trig(auto_trig)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cyc_n = 0;
  int wr_cnt = 0, total_wr = 0, last_addr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: phase 0=arming, 1=waiting for trigger, 2=capturing, 3=frame done.
  int div_tab[8] = '{1, 2, 5, 10, 100, 1000, 10000, 100000};
  int m_tb, m_cnt, m_se, m_ph, m_addr, m_acnt, m_auto;

  always @(negedge clk) begin
    logic [17:0] exp_v, act_v;
    bit chg, wexp;
    if (!rst_n) begin
      m_tb = 3; m_cnt = 0; m_se = 0; m_ph = 0; m_addr = 0; m_acnt = 0; m_auto = 0;
    end
    chg  = rst_n && ((tb_up && !tb_down && m_tb < 7) || (tb_down && !tb_up && m_tb > 0));
    wexp = !chg && m_se == 1 && ((m_ph == 1 && (trig || m_acnt + 1 >= AUTO)) || m_ph == 2);
    exp_v = {3'(m_tb), 1'(m_se), wexp, AW'(m_addr), (m_ph == 1 || m_ph == 2), (m_ph == 3), 1'(m_auto)};
    act_v = {tb_sel, sample_en, wr_en, wr_addr, busy, frame_ready, auto_trig};
    chk("outputs", 32'(act_v), 32'(exp_v));
    if (wr_en === 1'b1) begin
      total_wr++;
      if (wr_addr == 0) wr_cnt = 1;
      else wr_cnt++;
      last_addr = int'(wr_addr);
    end
    if (rst_n) begin
      if (chg) begin
        m_tb  = tb_up ? m_tb + 1 : m_tb - 1;
        m_cnt = 0; m_se = 0; m_ph = 0;
      end else begin
        case (m_ph)
          0: begin m_addr = 0; m_acnt = 0; m_ph = 1; end
          1: if (m_se == 1) begin
               m_acnt++;
               if (trig || m_acnt >= AUTO) begin
                 m_auto = trig ? 0 : 1; m_addr = 1; m_ph = 2;
               end
             end
          2: if (m_se == 1) begin
               if (m_addr == N - 1) m_ph = 3;
               else m_addr++;
             end
          default: if (rd_done) m_ph = 0;
        endcase
        if (m_cnt == div_tab[m_tb] - 1) begin m_cnt = 0; m_se = 1; end
        else begin m_cnt++; m_se = 0; end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    tb_up = 1'b0; tb_down = 1'b0; rd_done = 1'b0;
  endtask

  task automatic wait_se(input int lim);
    for (int i = 0; i < lim && sample_en !== 1'b1; i++) cyc();
  endtask

  task automatic wait_ready(input int lim);
    for (int i = 0; i < lim && frame_ready !== 1'b1; i++) cyc();
  endtask

  initial begin
    int c0, c1, t0, w0, cnt;
    bit hit;
    int up_exp[6] = '{4, 5, 6, 7, 7, 7};
    int dn_exp[9] = '{6, 5, 4, 3, 2, 1, 0, 0, 0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tb_sel", tb_sel, 3);
    chk("rst_sample_en", sample_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_ready", frame_ready, 0);

    // T1: idle at tb_sel=3, strobe every 10 clocks
    rst_n = 1'b1;
    c0 = cyc_n;
    wait_se(40);
    chk("t1_first_strobe", cyc_n - c0, 10);
    cyc();
    c1 = cyc_n - 1;
    wait_se(40);
    chk("t1_strobe_gap", cyc_n - c1, 10);
    chk("t1_frame_ready", frame_ready, 0);

    // T2: step up to saturation, then down to saturation
    for (int i = 0; i < 6; i++) begin
      tb_up = 1'b1; cyc();
      chk("t2_up", tb_sel, up_exp[i]);
    end
    for (int i = 0; i < 9; i++) begin
      tb_down = 1'b1; cyc();
      chk("t2_down", tb_sel, dn_exp[i]);
    end
    for (int i = 0; i < 4; i++) begin
      chk("t2_div1_strobe", sample_en, 1);
      cyc();
    end

    // T3: trigger on the 5th strobe after arming
    tb_up = 1'b1; cyc();
    tb_down = 1'b1; cyc();
    for (int i = 0; i < 10 && busy !== 1'b1; i++) cyc();
    chk("t3_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      chk("t3_pre_strobe", sample_en, 1);
      cyc();
    end
    trig = 1'b1;
    t0 = cyc_n;
    cyc();
    trig = 1'b0;
    chk("t3_first_write", wr_cnt, 1);
    wait_ready(2000);
    chk("t3_frame_ready", frame_ready, 1);
    chk("t3_ready_latency", cyc_n - t0, N);
    chk("t3_writes", wr_cnt, N);
    chk("t3_last_addr", last_addr, N - 1);
    chk("t3_auto_trig", auto_trig, 0);
    rd_done = 1'b1; cyc();
    chk("t3_rearm_busy", busy, 0);
    chk("t3_rearm_ready", frame_ready, 0);
    cyc();
    chk("t3_busy_after_arm", busy, 1);

    // T4: no trigger, auto trigger after AUTO strobes
    cnt = 0; hit = 0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      if (sample_en === 1'b1 && busy === 1'b1) cnt++;
      if (wr_en === 1'b1) hit = 1;
      else cyc();
    end
    chk("t4_auto_strobes", cnt, AUTO);
    chk("t4_auto_addr", wr_addr, 0);
    cyc();
    chk("t4_auto_flag", auto_trig, 1);
    wait_ready(2000);
    chk("t4_writes", wr_cnt, N);
    chk("t4_auto_hold", auto_trig, 1);
    rd_done = 1'b1; cyc();

    // T5: timebase change mid-capture aborts
    tb_up = 1'b1; cyc();
    trig = 1'b1;
    for (int i = 0; i < 3000 && wr_addr != 300; i++) cyc();
    chk("t5_addr", wr_addr, 300);
    trig = 1'b0;
    tb_up = 1'b1;
    w0 = total_wr;
    cyc();
    c0 = cyc_n;
    chk("t5_tb_sel", tb_sel, 2);
    chk("t5_abort_busy", busy, 0);
    wait_se(20);
    chk("t5_strobe_delay", cyc_n - c0, 5);
    repeat (20) cyc();
    chk("t5_no_writes", total_wr - w0, 0);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      tb_up   = ($urandom_range(0, 59) == 0);
      tb_down = ($urandom_range(0, 24) == 0);
      trig    = ($urandom_range(0, 7) == 0);
      rd_done = ($urandom_range(0, 15) == 0);
      cyc();
    end
    trig = 1'b0;

    // T6: simultaneous pulses, then reset during capture
    repeat (8) begin tb_down = 1'b1; cyc(); end
    chk("t6_floor", tb_sel, 0);
    tb_up = 1'b1; cyc();
    tb_up = 1'b1; cyc();
    tb_up = 1'b1; tb_down = 1'b1; cyc();
    chk("t6_both", tb_sel, 2);
    tb_down = 1'b1; cyc();
    tb_down = 1'b1; cyc();
    trig = 1'b1;
    for (int i = 0; i < 3000 && !(busy === 1'b1 && wr_addr == 100); i++) cyc();
    chk("t6_mid_addr", wr_addr, 100);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wr_en", wr_en, 0);
    chk("t6_rst_tb_sel", tb_sel, 3);
    chk("t6_rst_addr", wr_addr, 0);
    chk("t6_rst_busy", busy, 0);
    cyc();
    rst_n = 1'b1;
    wait_ready(8000);
    chk("t6_ready", frame_ready, 1);
    chk("t6_writes", wr_cnt, N);
    chk("t6_last_addr", last_addr, N - 1);
    chk("t6_auto", auto_trig, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
